// File: rtl/pool_row_sequencer.sv
// Streams one feature-map tile from the line buffer into the pooling unit, one row burst at a time.
// Optional perf_cycles busy-cycle counter is built when POOL_SEQ_PERF_EN is defined.
module pool_row_sequencer #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 16,
  parameter int DIM_W   = 16,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_row,
  input  logic [DIM_W-1:0]  cfg_col,
  input  logic              cfg_pool_en,
  input  logic              cfg_layer1,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pu_pool_en,
  output logic              pu_layer1,
  output logic [DIM_W-1:0]  pu_col,
  output logic              pu_valid_in,
  output logic [DATA_W-1:0] pu_data_in,
  input  logic              pu_pool_end
`ifdef POOL_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_WAIT_END,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DIM_W-1:0]    row_q, row_d;
  logic [DIM_W-1:0]    row_cnt_q, row_cnt_d;
  logic [DIM_W-1:0]    col_cnt_q, col_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                pend_q, pend_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rd_en_q, rd_en_d;
  logic                pool_en_q, pool_en_d;
  logic                layer1_q, layer1_d;
  logic [DIM_W-1:0]    col_q, col_d;
  logic                valid_q;
  logic [DATA_W-1:0]   data_q;
`ifdef POOL_SEQ_PERF_EN
  logic [31:0]         perf_q, perf_d;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case leaves it unassigned (no latches).
    state_d   = state_q;
    row_d     = row_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    gap_cnt_d = gap_cnt_q;
    addr_d    = addr_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    pool_en_d = pool_en_q;
    layer1_d  = layer1_q;
    col_d     = col_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_en_d   = 1'b0;
`ifdef POOL_SEQ_PERF_EN
    perf_d    = (busy_q && perf_q != '1) ? perf_q + 32'd1 : perf_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_row == '0 || cfg_col == '0) begin
            err_d = 1'b1;
          end else begin
            row_d     = cfg_row;
            col_d     = cfg_col;
            pool_en_d = cfg_pool_en;
            layer1_d  = cfg_layer1;
            row_cnt_d = '0;
            col_cnt_d = '0;
            addr_d    = cfg_base_addr;
            pend_d    = 1'b0;
            busy_d    = 1'b1;
            rd_en_d   = 1'b1;
            state_d   = S_ISSUE;
`ifdef POOL_SEQ_PERF_EN
            perf_d    = '0;
`endif
          end
        end
      end

      S_ISSUE: begin
        addr_d = addr_q + ADDR_ONE;
        if (col_cnt_q == col_q - DIM_ONE) begin
          col_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else begin
          col_cnt_d = col_cnt_q + DIM_ONE;
          rd_en_d   = 1'b1;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          // A row-end pulse on the transition edge is held so WAIT_END still sees it.
          pend_d  = pu_pool_end;
          state_d = S_WAIT_END;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_ONE;
        end
      end

      S_WAIT_END: begin
        if (pu_pool_end || pend_q) begin
          pend_d = 1'b0;
          if (row_cnt_q == row_q - DIM_ONE) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            row_cnt_d = row_cnt_q + DIM_ONE;
            rd_en_d   = 1'b1;
            state_d   = S_ISSUE;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      gap_cnt_q <= '0;
      addr_q    <= '0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      pool_en_q <= 1'b0;
      layer1_q  <= 1'b0;
      col_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
`ifdef POOL_SEQ_PERF_EN
      perf_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      addr_q    <= addr_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_en_q   <= rd_en_d;
      pool_en_q <= pool_en_d;
      layer1_q  <= layer1_d;
      col_q     <= col_d;
      valid_q   <= rd_en_q;
      data_q    <= rd_data;
`ifdef POOL_SEQ_PERF_EN
      perf_q    <= perf_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = addr_q;
  assign pu_pool_en  = pool_en_q;
  assign pu_layer1   = layer1_q;
  assign pu_col      = col_q;
  assign pu_valid_in = valid_q;
  assign pu_data_in  = data_q;
`ifdef POOL_SEQ_PERF_EN
  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pool_row_sequencer.sv
// Self-checking bench for pool_row_sequencer: vector table, hand-written corner sequences and random tiles.
// Also checks perf_cycles when POOL_SEQ_PERF_EN is defined.
module tb_pool_row_sequencer;
  localparam int DATA_W  = 256;
  localparam int ADDR_W  = 16;
  localparam int DIM_W   = 16;
  localparam int GAP_CYC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DIM_W-1:0]  cfg_row, cfg_col;
  logic              cfg_pool_en, cfg_layer1;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic              busy, done, err, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              pu_pool_en, pu_layer1;
  logic [DIM_W-1:0]  pu_col;
  logic              pu_valid_in;
  logic [DATA_W-1:0] pu_data_in;
  logic              pu_pool_end;
`ifdef POOL_SEQ_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  pool_row_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_pool_en(cfg_pool_en),
    .cfg_layer1(cfg_layer1), .cfg_base_addr(cfg_base_addr),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pu_pool_en(pu_pool_en), .pu_layer1(pu_layer1), .pu_col(pu_col),
    .pu_valid_in(pu_valid_in), .pu_data_in(pu_data_in),
    .pu_pool_end(pu_pool_end)
`ifdef POOL_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Configuration the DUT should be presenting after the last accepted start.
  int   last_col = 0;
  logic last_pen = 1'b0;
  logic last_l1  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          rows;
    int          cols;
    logic [15:0] base;
    logic        pen;
    logic        l1;
    int          dly;
    int          inj;
    int          restart;
    logic        exp_err;
    int          exp_reads;
    logic [15:0] exp_last;
  } vec_t;

  // Runs one tile and checks it against the transaction-level rules: reads are base+i for
  // i < rows*cols (mod 2^16), in rows bursts of cols; row r+1 may only start after the
  // r-th row-end pulse; pu_valid_in/pu_data_in are one-cycle delayed copies.
  task automatic run_tile(input string tag, input int rows, input int cols, input logic [15:0] base,
                          input logic pen, input logic l1, input int dly, input int inj,
                          input int restart, output int err_cnt, output int rd_cnt,
                          output logic [15:0] last_addr);
    logic exp_err = (rows == 0 || cols == 0);
    int budget = exp_err ? 8 : rows * (cols + dly + GAP_CYC + 6) + 20;
    int done_cnt = 0, busy_cnt = 0, addr_bad = 0, bursts = 0, burst_bad = 0;
    int run_len = 0, first_rd = -1, valid_bad = 0, gap_bad = 0, data_bad = 0;
    int low_run = 0, vbursts = 0, early_bad = 0, pulses = 0, pe_timer = -1;
    int done_at = -1, post_done_bad = 0, perf_seen = 0;
    logic prev_rd_en = 1'b0, prev_valid = 1'b0;
    err_cnt = 0; rd_cnt = 0; last_addr = 16'h0;

    @(negedge clk);
    start = 1'b1; cfg_row = 16'(rows); cfg_col = 16'(cols); cfg_base_addr = base;
    cfg_pool_en = pen; cfg_layer1 = l1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start = (cyc == restart);
      if (err)  err_cnt++;
      if (done) begin done_cnt++; if (done_at < 0) done_at = cyc; end
      if (busy) busy_cnt++;
      if (done && busy) post_done_bad++;
      if (done_at >= 0 && cyc > done_at && (busy || rd_en)) post_done_bad++;
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (!prev_rd_en && bursts > pulses) early_bad++;
        if (rd_addr !== 16'(base + 16'(rd_cnt))) addr_bad++;
        last_addr = rd_addr;
        rd_cnt++; run_len++;
      end
      if (pu_valid_in !== prev_rd_en) valid_bad++;
      if (pu_data_in !== rd_data) data_bad++;
      if (pu_valid_in && !prev_valid) begin
        if (vbursts > 0 && low_run < GAP_CYC) gap_bad++;
        vbursts++;
      end
      low_run = pu_valid_in ? 0 : low_run + 1;
      if (done && pulses < rows) early_bad++;

      pu_pool_end = (cyc == inj);
      if (pe_timer > 0) begin
        pe_timer--;
        if (pe_timer == 0) begin pu_pool_end = 1'b1; pulses++; pe_timer = -1; end
      end
      if (!rd_en && prev_rd_en) begin
        if (run_len != cols) burst_bad++;
        bursts++; run_len = 0; pe_timer = dly;
      end
      prev_rd_en = rd_en;
      prev_valid = pu_valid_in;
      rd_data = {8{$urandom}};
`ifdef POOL_SEQ_PERF_EN
      if (done) perf_seen = int'(perf_cycles);
`endif
      if (done_at >= 0 && cyc >= done_at + 3) break;
    end
    pu_pool_end = 1'b0;

    if (exp_err) begin
      check({tag, " err_pulse"}, 64'(err_cnt), 64'd1);
      check({tag, " err_busy"}, 64'(busy_cnt), 64'd0);
      check({tag, " err_done"}, 64'(done_cnt), 64'd0);
      check({tag, " err_cfg_hold"}, {pu_pool_en, pu_layer1, pu_col}, {last_pen, last_l1, 16'(last_col)});
    end else begin
      last_col = cols; last_pen = pen; last_l1 = l1;
      check({tag, " no_err"}, 64'(err_cnt), 64'd0);
      check({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
      check({tag, " addr_seq"}, 64'(addr_bad), 64'd0);
      check({tag, " bursts"}, 64'(bursts), 64'(rows));
      check({tag, " burst_len"}, 64'(burst_bad), 64'd0);
      check({tag, " first_rd_cyc"}, 64'(first_rd), 64'd1);
      check({tag, " row_order"}, 64'(early_bad), 64'd0);
      check({tag, " valid_pipe"}, 64'(valid_bad), 64'd0);
      check({tag, " valid_gap"}, 64'(gap_bad), 64'd0);
      check({tag, " post_done"}, 64'(post_done_bad), 64'd0);
      check({tag, " cfg_out"}, {pu_pool_en, pu_layer1, pu_col}, {pen, l1, 16'(cols)});
`ifdef POOL_SEQ_PERF_EN
      check({tag, " perf"}, 64'(perf_seen), 64'(busy_cnt));
      check({tag, " perf_hold"}, 64'(perf_cycles), 64'(busy_cnt));
`endif
    end
    check({tag, " data_pipe"}, 64'(data_bad), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int ec, rc, n, dn, pe;
    logic fell;
    logic [15:0] la;

    vecs[0] = '{2, 4, 16'h0010, 1'b1, 1'b0, 5, -1, -1, 1'b0,  8, 16'h0017};
    vecs[1] = '{2, 0, 16'h0000, 1'b1, 1'b1, 2, -1, -1, 1'b1,  0, 16'h0000};
    vecs[2] = '{1, 2, 16'h0100, 1'b0, 1'b1, 2, -1, -1, 1'b0,  2, 16'h0101};
    vecs[3] = '{1, 4, 16'hFFFE, 1'b1, 1'b0, 3, -1, -1, 1'b0,  4, 16'h0001};
    vecs[4] = '{0, 3, 16'h0020, 1'b0, 1'b0, 2, -1, -1, 1'b1,  0, 16'h0000};
    vecs[5] = '{2, 4, 16'h0200, 1'b1, 1'b1, 4,  2,  3, 1'b0,  8, 16'h0207};
    vecs[6] = '{3, 1, 16'h0300, 1'b0, 1'b1, 1, -1, -1, 1'b0,  3, 16'h0302};
    vecs[7] = '{2, 5, 16'h1234, 1'b1, 1'b0, 6, -1, -1, 1'b0, 10, 16'h123D};

    rst = 1'b1; start = 1'b0; cfg_row = '0; cfg_col = '0; cfg_pool_en = 1'b0;
    cfg_layer1 = 1'b0; cfg_base_addr = '0; rd_data = '0; pu_pool_end = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {busy, done, err, rd_en, pu_valid_in}, 64'd0);
    check("reset_addr_cfg", {rd_addr, pu_pool_en, pu_layer1, pu_col}, 64'd0);
    check("reset_data", 64'(pu_data_in != '0), 64'd0);
`ifdef POOL_SEQ_PERF_EN
    check("reset_perf", 64'(perf_cycles), 64'd0);
`endif
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_tile($sformatf("vec%0d", i), vecs[i].rows, vecs[i].cols, vecs[i].base, vecs[i].pen,
               vecs[i].l1, vecs[i].dly, vecs[i].inj, vecs[i].restart, ec, rc, la);
      check($sformatf("vec%0d err", i), 64'(ec != 0), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d reads", i), 64'(rc), 64'(vecs[i].exp_reads));
      check($sformatf("vec%0d last_addr", i), 64'(la), 64'(vecs[i].exp_last));
    end

    // Reset in the middle of row 1's burst of a 3x8 tile.
    @(negedge clk);
    start = 1'b1; cfg_row = 16'd3; cfg_col = 16'd8; cfg_base_addr = 16'h0400;
    cfg_pool_en = 1'b1; cfg_layer1 = 1'b0;
    n = 0; dn = 0; pe = -1; fell = 1'b0;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      pu_pool_end = 1'b0;
      if (done) dn++;
      if (rd_en) n++;
      if (pe > 0) begin pe--; if (pe == 0) pu_pool_end = 1'b1; end
      if (!rd_en && n == 8 && !fell) begin fell = 1'b1; pe = 2; end
      if (n == 12) begin rst = 1'b1; break; end
    end
    check("rst_mid_reached", 64'(n), 64'd12);
    @(negedge clk);
    pu_pool_end = 1'b0;
    check("rst_mid_outputs", {rd_en, pu_valid_in, busy, done}, 64'd0);
    check("rst_mid_cfg", {rd_addr, pu_col}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    if (done) dn++;
    check("rst_mid_no_done", 64'(dn), 64'd0);
    last_col = 0; last_pen = 1'b0; last_l1 = 1'b0;
    run_tile("post_rst", 3, 8, 16'h0400, 1'b1, 1'b0, 2, -1, -1, ec, rc, la);
    check("post_rst reads", 64'(rc), 64'd24);

    for (int t = 0; t < 20; t++) begin
      int r  = int'($urandom_range(1, 4));
      int c  = int'($urandom_range(1, 12));
      int d  = int'($urandom_range(1, 6));
      logic [15:0] b = 16'($urandom);
      run_tile($sformatf("rnd%0d", t), r, c, b, 1'($urandom), 1'($urandom), d, -1, -1, ec, rc, la);
      check($sformatf("rnd%0d reads", t), 64'(rc), 64'(r * c));
      check($sformatf("rnd%0d last_addr", t), 64'(la), 64'(16'(b + 16'(r * c - 1))));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
